// File: rtl/decode_issue.sv
// decode_issue: ID/EX issue stage with EX/MEM/WB forwarding, load-use stall and a registered valid/ready slot
module decode_issue (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [7:0]  in_op,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic        in_use_rs,
    input  logic        in_use_rt,
    input  logic [4:0]  in_dest,
    input  logic        in_wr,
    input  logic        in_load,
    output logic [4:0]  rf_ra1,
    output logic [4:0]  rf_ra2,
    input  logic [31:0] rf_rd1,
    input  logic [31:0] rf_rd2,
    input  logic        ex_wr,
    input  logic        mem_wr,
    input  logic        wb_wr,
    input  logic [4:0]  ex_dest,
    input  logic [4:0]  mem_dest,
    input  logic [4:0]  wb_dest,
    input  logic        ex_load,
    input  logic [31:0] ex_res,
    input  logic [31:0] mem_res,
    input  logic [31:0] wb_res,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_imm,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [7:0]  out_op,
    output logic [4:0]  out_dest,
    output logic        out_wr,
    output logic        out_load,
    output logic [31:0] stall_cnt
);
    logic        valid_q, valid_d, wr_q, load_q;
    logic [31:0] pc_q, imm_q, src1_q, src2_q, src1_d, src2_d, cnt_q, cnt_d;
    logic [7:0]  op_q;
    logic [4:0]  dest_q;
    logic        hazard, adv, take;

    assign rf_ra1 = in_rs;
    assign rf_ra2 = in_rt;
    // WB is forwarded because the register file returns the pre-write value
    assign src1_d = (in_rs == 5'd0) ? 32'd0 :
                    (ex_wr && ex_dest == in_rs) ? ex_res :
                    (mem_wr && mem_dest == in_rs) ? mem_res :
                    (wb_wr && wb_dest == in_rs) ? wb_res : rf_rd1;
    assign src2_d = (in_rt == 5'd0) ? 32'd0 :
                    (ex_wr && ex_dest == in_rt) ? ex_res :
                    (mem_wr && mem_dest == in_rt) ? mem_res :
                    (wb_wr && wb_dest == in_rt) ? wb_res : rf_rd2;
    assign hazard = in_valid && ex_wr && ex_load && ex_dest != 5'd0 &&
                    ((in_use_rs && in_rs == ex_dest) || (in_use_rt && in_rt == ex_dest));
    assign adv      = !valid_q || out_ready;
    assign in_ready = adv && !hazard;
    assign take     = adv && in_valid && !hazard && !flush;
    assign valid_d  = flush ? 1'b0 : adv ? take : valid_q;
    assign cnt_d    = (in_valid && hazard && adv && !flush) ? cnt_q + 32'd1 : cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            cnt_q   <= 32'd0;
            pc_q    <= 32'd0;
            imm_q   <= 32'd0;
            src1_q  <= 32'd0;
            src2_q  <= 32'd0;
            op_q    <= 8'd0;
            dest_q  <= 5'd0;
            wr_q    <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (take) begin
                pc_q   <= in_pc;
                imm_q  <= in_imm;
                src1_q <= src1_d;
                src2_q <= src2_d;
                op_q   <= in_op;
                dest_q <= in_dest;
                wr_q   <= in_wr;
                load_q <= in_load;
            end
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_imm   = imm_q;
    assign out_src1  = src1_q;
    assign out_src2  = src2_q;
    assign out_op    = op_q;
    assign out_dest  = dest_q;
    assign out_wr    = wr_q;
    assign out_load  = load_q;
    assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: randomized and directed scoreboard bench for decode_issue
module tb_decode_issue;
    logic        clk = 1'b0, reset;
    logic        in_valid, in_ready, in_use_rs, in_use_rt, in_wr, in_load;
    logic [31:0] in_pc, in_imm, rf_rd1, rf_rd2, ex_res, mem_res, wb_res;
    logic [7:0]  in_op;
    logic [4:0]  in_rs, in_rt, in_dest, rf_ra1, rf_ra2, ex_dest, mem_dest, wb_dest;
    logic        ex_wr, mem_wr, wb_wr, ex_load, flush, out_valid, out_ready, out_wr, out_load;
    logic [31:0] out_pc, out_imm, out_src1, out_src2, stall_cnt;
    logic [7:0]  out_op;
    logic [4:0]  out_dest;

    decode_issue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_op(in_op), .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_use_rs(in_use_rs),
        .in_use_rt(in_use_rt), .in_dest(in_dest), .in_wr(in_wr), .in_load(in_load),
        .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .ex_dest(ex_dest), .mem_dest(mem_dest),
        .wb_dest(wb_dest), .ex_load(ex_load), .ex_res(ex_res), .mem_res(mem_res), .wb_res(wb_res),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_imm(out_imm), .out_src1(out_src1), .out_src2(out_src2), .out_op(out_op),
        .out_dest(out_dest), .out_wr(out_wr), .out_load(out_load), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc, imm, src1, src2;
        logic [7:0]  op;
        logic [4:0]  dest;
        logic        wr, load;
    } item_t;

    item_t       sb[$];
    int          n_chk = 0, n_fail = 0;
    logic        m_valid;
    logic [31:0] m_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference operand: register zero reads 0, otherwise youngest producing stage wins
    function automatic logic [31:0] resolve(input logic [4:0] r, input logic [31:0] rf);
        logic        w[3];
        logic [4:0]  d[3];
        logic [31:0] v[3];
        w = '{ex_wr, mem_wr, wb_wr};
        d = '{ex_dest, mem_dest, wb_dest};
        v = '{ex_res, mem_res, wb_res};
        if (r == 0) return 0;
        for (int i = 0; i < 3; i++) if (w[i] && d[i] == r) return v[i];
        return rf;
    endfunction

    initial forever begin
        item_t e;
        @(negedge clk);
        if (!reset && out_valid === 1'b1 && out_ready && !flush) begin
            if (sb.size() == 0) chk("spurious out_valid", {31'd0, out_valid}, 32'd0);
            else begin
                e = sb.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_imm", out_imm, e.imm);
                chk("out_src1", out_src1, e.src1);
                chk("out_src2", out_src2, e.src2);
                chk("out_ctl", {16'd0, out_op, out_dest, out_wr, out_load}, {16'd0, e.op, e.dest, e.wr, e.load});
            end
        end
    end

    task automatic cycle();
        logic  hz, adv, acc;
        item_t e;
        @(negedge clk);
        #1;
        hz  = in_valid && ex_wr && ex_load && ex_dest != 0 &&
              ((in_use_rs && in_rs == ex_dest) || (in_use_rt && in_rt == ex_dest));
        adv = !m_valid || out_ready;
        acc = adv && in_valid && !hz && !flush;
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        chk("in_ready", {31'd0, in_ready}, {31'd0, adv && !hz});
        chk("stall_cnt", stall_cnt, m_cnt);
        chk("rf_ra", {22'd0, rf_ra1, rf_ra2}, {22'd0, in_rs, in_rt});
        if (in_valid && hz && adv && !flush) m_cnt++;
        if (flush && m_valid && sb.size() > 0) void'(sb.pop_front());
        if (acc) begin
            e = '{pc: in_pc, imm: in_imm, src1: resolve(in_rs, rf_rd1), src2: resolve(in_rt, rf_rd2),
                  op: in_op, dest: in_dest, wr: in_wr, load: in_load};
            sb.push_back(e);
        end
        m_valid = flush ? 1'b0 : adv ? acc : m_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {in_valid, in_use_rs, in_use_rt, in_wr, in_load, ex_wr, mem_wr, wb_wr, ex_load, flush} = '0;
        {in_pc, in_imm, rf_rd1, rf_rd2, ex_res, mem_res, wb_res} = '0;
        {in_op, in_rs, in_rt, in_dest, ex_dest, mem_dest, wb_dest} = '0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] held;
        idle();
        reset = 1'b1;
        m_valid = 1'b0;
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset fields", out_pc | out_imm | out_src1 | out_src2 | {24'd0, out_op} | {27'd0, out_dest}, 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        chk("reset in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // forwarding priority EX > MEM > WB > RF
        in_valid = 1; in_rs = 5; in_use_rs = 1; in_pc = 32'h100;
        ex_wr = 1; ex_dest = 5; ex_res = 32'h11;
        mem_wr = 1; mem_dest = 5; mem_res = 32'h22; rf_rd1 = 32'h33;
        cycle(); chk("fwd ex", out_src1, 32'h11);
        ex_wr = 0; cycle(); chk("fwd mem", out_src1, 32'h22);
        mem_wr = 0; wb_wr = 1; wb_dest = 5; wb_res = 32'h44;
        cycle(); chk("fwd wb", out_src1, 32'h44);
        wb_wr = 0; cycle(); chk("fwd rf", out_src1, 32'h33);
        // register zero never forwarded and never stalls
        in_rs = 0; ex_wr = 1; ex_dest = 0; ex_res = 32'hDEAD; ex_load = 1;
        cycle(); chk("r0 value", out_src1, 32'd0);
        chk("r0 no stall", {31'd0, out_valid}, 32'd1);
        // load-use stall then forward from MEM
        in_use_rs = 0; in_rt = 8; in_use_rt = 1; ex_dest = 8; ex_res = 32'hBAD;
        #1 chk("load-use in_ready", {31'd0, in_ready}, 32'd0);
        cycle(); chk("load-use bubble", {31'd0, out_valid}, 32'd0);
        ex_wr = 0; mem_wr = 1; mem_dest = 8; mem_res = 32'h55;
        cycle(); chk("load-use src2", out_src2, 32'h55);
        chk("load-use stall_cnt", stall_cnt, 32'd1);
        mem_wr = 0; ex_wr = 1; in_use_rt = 0;
        #1 chk("unused src in_ready", {31'd0, in_ready}, 32'd1);
        cycle(); chk("unused src valid", {31'd0, out_valid}, 32'd1);
        chk("unused src stall_cnt", stall_cnt, 32'd1);
        // backpressure holds the slot
        ex_wr = 0; held = out_pc; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            in_pc = $urandom; in_rs = 5'($urandom); rf_rd1 = $urandom;
            cycle();
            chk("held out_pc", out_pc, held);
            chk("held in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1; in_pc = 32'h1234;
        cycle(); chk("release out_pc", out_pc, 32'h1234);
        // flush with an empty slot swallows the accepted input
        in_valid = 0; cycle();
        in_valid = 1; in_pc = 32'hF1; out_ready = 0; flush = 1;
        #1 chk("flush in_ready", {31'd0, in_ready}, 32'd1);
        cycle(); chk("flush out_valid", {31'd0, out_valid}, 32'd0);
        flush = 0; in_valid = 0; out_ready = 1;
        cycle(); chk("flush dropped", {31'd0, out_valid}, 32'd0);
        // async reset while full and stalling
        in_valid = 1; in_pc = 32'h77; cycle();
        ex_wr = 1; ex_load = 1; ex_dest = 3; in_rs = 3; in_use_rs = 1; out_ready = 1;
        cycle();
        #2 reset = 1;
        #1;
        chk("async reset out_valid", {31'd0, out_valid}, 32'd0);
        chk("async reset stall_cnt", stall_cnt, 32'd0);
        sb.delete(); m_valid = 0; m_cnt = 0; idle();
        @(negedge clk) reset = 0;
        @(posedge clk);
        #1;
        for (int n = 0; n < 600; n++) begin
            in_valid = ($urandom_range(9) < 7); out_ready = ($urandom_range(9) < 7);
            flush = ($urandom_range(19) == 0);
            in_pc = $urandom; in_imm = $urandom; in_op = 8'($urandom); in_dest = 5'($urandom);
            in_wr = 1'($urandom); in_load = 1'($urandom);
            in_rs = 5'($urandom_range(7)); in_rt = 5'($urandom_range(7));
            in_use_rs = 1'($urandom); in_use_rt = 1'($urandom);
            ex_wr = 1'($urandom); mem_wr = 1'($urandom); wb_wr = 1'($urandom);
            ex_load = ($urandom_range(9) < 3);
            ex_dest = 5'($urandom_range(7)); mem_dest = 5'($urandom_range(7)); wb_dest = 5'($urandom_range(7));
            ex_res = $urandom; mem_res = $urandom; wb_res = $urandom; rf_rd1 = $urandom; rf_rd2 = $urandom;
            cycle();
        end
        idle();
        repeat (3) cycle();
        chk("scoreboard drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
